// File: rtl/imem_program_loader.sv
// Instruction-memory writer: packs an MSB-first byte stream into 32-bit words,
// checks opcodes, writes consecutive addresses and releases the CPU after HALT.
module imem_program_loader #(
  parameter int ADDR_W   = 6,
  parameter int CHECK_OP = 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

  localparam logic [5:0]        OP_HALT  = 6'b111111;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_cnt;
  logic [31:0]       word;
  logic [31:0]       next_word;
  logic              accept;
  logic              next_ok;
  logic              word_ok;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010,
      6'b010000, 6'b010001, 6'b010010,
      6'b100000, 6'b100110, 6'b100111,
      6'b110000, 6'b111111: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  always_comb begin
    in_ready  = (state == RECV);
    busy      = (state == RECV) || (state == WRITE);
    accept    = in_valid && in_ready;
    next_word = {word[23:0], in_data};
    next_ok   = (CHECK_OP == 0) || op_legal(next_word[31:26]);
    word_ok   = (CHECK_OP == 0) || op_legal(word[31:26]);
  end

  // The write strobe is registered on the edge that accepts the 4th byte, so it
  // is high exactly during the single WRITE cycle; WRITE then picks the exit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      addr       <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= RECV;
            addr       <= '0;
            byte_cnt   <= '0;
            word_count <= '0;
            err        <= 1'b0;
            cpu_run    <= 1'b0;
          end
        end
        RECV: begin
          if (accept) begin
            word     <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= WRITE;
              if (next_ok) begin
                imem_we    <= 1'b1;
                imem_addr  <= addr;
                imem_wdata <= next_word;
                word_count <= word_count + 1'b1;
              end
            end
          end
        end
        WRITE: begin
          if (!word_ok) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (word[31:26] == OP_HALT) begin
            state   <= DONE;
            cpu_run <= 1'b1;
          end else if (addr == ADDR_MAX) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            addr  <= addr + 1'b1;
            state <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader (ADDR_W=2, CHECK_OP=1).
module tb_imem_program_loader;
  logic        CLK = 1'b0;
  logic        RST_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        err;
  logic [2:0]  word_count;

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  int base;
  logic [1:0]  log_addr [0:63];
  logic [31:0] log_data [0:63];

  imem_program_loader #(.ADDR_W(2), .CHECK_OP(1)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .busy(busy), .err(err), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      log_addr[wcnt % 64] = imem_addr;
      log_data[wcnt % 64] = imem_wdata;
      wcnt = wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) chk("byte_accept_timeout", 32'(n), 32'd0);
    @(negedge CLK);
    in_valid = 1'b0;
    if (gap) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] t;
    t = w;
    send_byte(t[31:24], gap);
    send_byte(t[23:16], gap);
    send_byte(t[15:8], gap);
    send_byte(t[7:0], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [1:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, 32'(log_addr[idx % 64]), 32'(a));
    chk({tag, "_data"}, log_data[idx % 64], d);
  endtask

  initial begin
    RST_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_no_start", 32'(busy), 32'd0);

    // Test 1: basic two-word load, with latency checks on the first word
    base = wcnt;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    send_word(32'h04220005, 1'b0);
    chk("t1_we_after_byte3", 32'(imem_we), 32'd1);
    chk("t1_ready_in_write", 32'(in_ready), 32'd0);
    chk("t1_wc_in_write", 32'(word_count), 32'd1);
    @(negedge CLK);
    chk("t1_we_one_cycle", 32'(imem_we), 32'd0);
    chk("t1_ready_back", 32'(in_ready), 32'd1);
    send_word(32'hFC000000, 1'b0);
    wait_end("t1_end");
    chk("t1_nwrites", 32'(wcnt - base), 32'd2);
    chk_write("t1_w0", base, 2'd0, 32'h04220005);
    chk_write("t1_w1", base + 1, 2'd1, 32'hFC000000);
    chk("t1_cpu_run", 32'(cpu_run), 32'd1);
    chk("t1_word_count", 32'(word_count), 32'd2);
    chk("t1_err", 32'(err), 32'd0);
    repeat (2) @(negedge CLK);
    chk("t1_hold_addr", 32'(imem_addr), 32'd1);
    chk("t1_hold_wdata", imem_wdata, 32'hFC000000);

    // Tests 2 and 6: restart from DONE, gapped stream, start ignored mid-RECV
    base = wcnt;
    pulse_start();
    chk("t6_cpu_run_drop", 32'(cpu_run), 32'd0);
    chk("t6_restart_busy", 32'(busy), 32'd1);
    chk("t6_wc_cleared", 32'(word_count), 32'd0);
    send_byte(8'h04, 1'b1);
    send_byte(8'h22, 1'b1);
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_word(32'hFC000000, 1'b1);
    wait_end("t2_end");
    chk("t2_nwrites", 32'(wcnt - base), 32'd2);
    chk_write("t2_w0", base, 2'd0, 32'h04220005);
    chk_write("t2_w1", base + 1, 2'd1, 32'hFC000000);
    chk("t2_cpu_run", 32'(cpu_run), 32'd1);
    chk("t2_word_count", 32'(word_count), 32'd2);

    // Test 3: illegal opcode 000011 as second word aborts; start recovers
    base = wcnt;
    pulse_start();
    send_word(32'h04220005, 1'b0);
    send_word(32'h0C000000, 1'b0);
    wait_end("t3_end");
    chk("t3_nwrites", 32'(wcnt - base), 32'd1);
    chk_write("t3_w0", base, 2'd0, 32'h04220005);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_cpu_run", 32'(cpu_run), 32'd0);
    chk("t3_word_count", 32'(word_count), 32'd1);
    pulse_start();
    chk("t3_err_cleared", 32'(err), 32'd0);
    send_word(32'hFC000000, 1'b0);
    wait_end("t3_reload_end");
    chk("t3_reload_nwrites", 32'(wcnt - base), 32'd2);
    chk_write("t3_reload", base + 1, 2'd0, 32'hFC000000);
    chk("t3_reload_run", 32'(cpu_run), 32'd1);
    chk("t3_reload_wc", 32'(word_count), 32'd1);

    // Test 4: four non-HALT words fill the 4-word memory -> overflow error
    base = wcnt;
    pulse_start();
    send_word(32'h04000001, 1'b0);
    send_word(32'h40000002, 1'b0);
    send_word(32'h80000003, 1'b0);
    send_word(32'hC0000004, 1'b0);
    wait_end("t4_end");
    chk("t4_nwrites", 32'(wcnt - base), 32'd4);
    chk_write("t4_w0", base, 2'd0, 32'h04000001);
    chk_write("t4_w1", base + 1, 2'd1, 32'h40000002);
    chk_write("t4_w2", base + 2, 2'd2, 32'h80000003);
    chk_write("t4_w3", base + 3, 2'd3, 32'hC0000004);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_cpu_run", 32'(cpu_run), 32'd0);
    chk("t4_word_count", 32'(word_count), 32'd4);

    // Test 5: asynchronous reset in the middle of a word
    base = wcnt;
    pulse_start();
    send_byte(8'hFC, 1'b0);
    send_byte(8'h00, 1'b0);
    #2 RST_n = 1'b0;
    #1;
    chk("t5_async_addr", 32'(imem_addr), 32'd0);
    chk("t5_async_wdata", imem_wdata, 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_ready", 32'(in_ready), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    chk("t5_no_write", 32'(wcnt - base), 32'd0);
    pulse_start();
    send_word(32'hFC000000, 1'b0);
    wait_end("t5_end");
    chk("t5_nwrites", 32'(wcnt - base), 32'd1);
    chk_write("t5_w0", base, 2'd0, 32'hFC000000);
    chk("t5_cpu_run", 32'(cpu_run), 32'd1);
    chk("t5_word_count", 32'(word_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
